uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries, power of two, legal range 2..16.
REQ-003 The block SHALL have parameter CLKS_PER_BIT, default 16, txclk cycles per serial bit, legal range 1..4096.
REQ-004 The block SHALL have port txclk, input, 1, transmit clock; reset is reset, asynchronous, active-high; clock is txclk.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port ld_tx_data, input, 1, push request for tx_data into the FIFO.
REQ-007 The block SHALL have port tx_data, input, DATA_W, word to enqueue.
REQ-008 The block SHALL have port ld_ready, output, 1, high when the FIFO is not full.
REQ-009 The block SHALL have port tx_enable, input, 1, permission to start new frames.
REQ-010 The block SHALL have port stop2, input, 1, selects 2 stop bits (else 1); sampled at frame start.
REQ-011 The block SHALL have port clr_ovr, input, 1, clears tx_over_run.
REQ-012 The block SHALL have port tx_out, output, 1, serial line, idle high.
REQ-013 The block SHALL have port tx_empty, output, 1, high when the FIFO is empty and the FSM is IDLE.
REQ-014 The block SHALL have port tx_busy, output, 1, high while the FSM is not IDLE.
REQ-015 The block SHALL have port tx_over_run, output, 1, sticky flag for a push while full.
REQ-016 The block SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-017 The block SHALL accept a push only when ld_tx_data && ld_ready; a push while full is dropped and sets tx_over_run next cycle.
REQ-018 The block SHALL clear tx_over_run on clr_ovr; if clr_ovr and an overflowing push coincide, set wins.
REQ-019 The block SHALL compute ld_ready from current occupancy only; a same-cycle pop does not free a slot for a push.
REQ-020 The block SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 In IDLE with the FIFO non-empty and tx_enable high, the block SHALL pop the head word, latch it and stop2, and enter START; tx_out goes low on the following cycle.
REQ-022 The block SHALL hold each bit for exactly CLKS_PER_BIT cycles using a baud counter reloaded at every bit boundary.
REQ-023 The block SHALL send DATA_W data bits LSB first, then PARITY if compiled in, then 1 or 2 high stop bits, then return to IDLE.
REQ-024 The block SHALL start back-to-back frames with no idle gap when the FIFO is non-empty and tx_enable is high at the end of STOP.
REQ-025 The block SHALL finish the frame in progress when tx_enable drops mid-frame, and start no new frame until it is high again.
REQ-026 The block SHALL update fifo_level on every push and pop; a simultaneous push and pop leaves it unchanged, with read and write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-027 On reset the block SHALL drive tx_out=1, tx_empty=1, tx_busy=0, tx_over_run=0, ld_ready=1, fifo_level=0, FSM=IDLE, and clear pointers and counters.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, discard FIFO contents, and force the line high.

Configuration
REQ-029 With UART_TX_PARITY_EN defined, the block SHALL add input parity_odd (1 bit, sampled at frame start) and transmit one parity bit: even parity when 0, odd parity when 1.
REQ-030 Without UART_TX_PARITY_EN, the block SHALL have no PARITY state and no parity_odd port, and the frame SHALL go from the last data bit directly to STOP.

Structure
REQ-031 The shared package uart_pkg SHALL hold the FSM state enum typedef and the legal-range constants for DATA_W and CLKS_PER_BIT.
REQ-032 The FIFO SHALL be a separate sub-module, uart_tx_fifo, parameterised by width and depth, with push, pop, full, empty and level signals.

Verification
REQ-033 With DATA_W=8, CLKS_PER_BIT=4 and stop2=0, push 0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; tx_empty returns to 1 after the stop bit.
REQ-034 With DATA_W=8, FIFO_DEPTH=4 and tx_enable=0, push 5 words -> ld_ready=0 after the 4th push, tx_over_run=1 after the 5th, fifo_level=4.
REQ-035 With UART_TX_PARITY_EN defined and parity_odd=1, push 0x03 -> parity bit = 1; with parity_odd=0 -> parity bit = 0.
REQ-036 With stop2=1, push 0x00 then 0xFF -> two stop bit-times (8 cycles at CLKS_PER_BIT=4) between frames, no idle gap.
REQ-037 Assert reset during data bit 3 -> tx_out=1 asynchronously, fifo_level=0, tx_busy=0; the next push sends a complete fresh frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, legal parameter
// ranges and the parity helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int DATA_W_MIN       = 5;
  localparam int DATA_W_MAX       = 9;
  localparam int CLKS_PER_BIT_MIN = 1;
  localparam int CLKS_PER_BIT_MAX = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  // Parity bit over a zero-extended word: even parity when odd==0.
  function automatic logic parity_bit(input logic [15:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Load handshake between a word producer and the UART transmitter.
interface uart_tx_cfg_if #(parameter int DATA_W = 8);
  logic              ld_tx_data;
  logic [DATA_W-1:0] tx_data;
  logic              ld_ready;

  modport master (output ld_tx_data, output tx_data, input ld_ready);
  modport slave  (input ld_tx_data, input tx_data, output ld_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit word FIFO: power-of-two depth, pointers wrap naturally,
// full/empty/level derived from an occupancy counter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             txclk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];
  // Full/empty gate here so callers can present raw requests.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy bookkeeping; push+pop together keeps the level.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge txclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: FIFO-fed, LSB-first frames with 1 or 2
// stop bits and back-to-back frame starts.
// Optional feature macro: UART_TX_PARITY_EN (parity_odd input + parity bit).
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                          txclk,
  input  logic                          reset,
  uart_tx_cfg_if.slave                  bus,
  input  logic                          tx_enable,
  input  logic                          stop2,
  input  logic                          clr_ovr,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx_out,
  output logic                          tx_empty,
  output logic                          tx_busy,
  output logic                          tx_over_run,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic              fifo_full, fifo_empty, pop;
  logic [DATA_W-1:0] head;

  tx_state_e         state_q;
  logic [CNT_W-1:0]  baud_q;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] shreg_q;
  logic              stop2_q, stop_left_q, tx_q, ovr_q;
`ifdef UART_TX_PARITY_EN
  logic              par_q;
`endif
  logic              baud_done, frame_end;

  uart_tx_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .txclk   (txclk),
    .reset   (reset),
    .push_i  (bus.ld_tx_data),
    .wdata_i (bus.tx_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign bus.ld_ready = !fifo_full;
  assign baud_done    = (baud_q == '0);
  // Last cycle of the final stop bit: a new frame may start here with no gap.
  assign frame_end    = (state_q == ST_STOP) && baud_done && !stop_left_q;
  assign pop          = ((state_q == ST_IDLE) || frame_end) && !fifo_empty && tx_enable;

  assign tx_out      = tx_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign tx_empty    = fifo_empty && (state_q == ST_IDLE);
  assign tx_over_run = ovr_q;

  // Frame sequencer: start, data LSB first, optional parity, stop bit(s).
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      stop2_q     <= 1'b0;
      stop_left_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else if (pop) begin
      state_q <= ST_START;
      shreg_q <= head;
      stop2_q <= stop2;
`ifdef UART_TX_PARITY_EN
      par_q   <= parity_bit(16'(head), parity_odd);
`endif
      bit_q   <= '0;
      baud_q  <= BIT_LAST;
      tx_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: tx_q <= 1'b1;
        ST_START: begin
          if (baud_done) begin
            state_q <= ST_DATA;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            baud_q  <= BIT_LAST;
          end else baud_q <= baud_q - 1'b1;
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_q <= BIT_LAST;
            if (bit_q == 4'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q     <= ST_PARITY;
              tx_q        <= par_q;
`else
              state_q     <= ST_STOP;
              tx_q        <= 1'b1;
              stop_left_q <= stop2_q;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else baud_q <= baud_q - 1'b1;
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            state_q     <= ST_STOP;
            tx_q        <= 1'b1;
            stop_left_q <= stop2_q;
            baud_q      <= BIT_LAST;
          end else baud_q <= baud_q - 1'b1;
        end
`endif
        ST_STOP: begin
          if (baud_done) begin
            baud_q <= BIT_LAST;
            if (stop_left_q) stop_left_q <= 1'b0;
            else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else baud_q <= baud_q - 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  // Sticky overrun: a push against a full FIFO beats a same-cycle clear.
  always_ff @(posedge txclk or posedge reset) begin
    if (reset)                             ovr_q <= 1'b0;
    else if (bus.ld_tx_data && fifo_full)  ovr_q <= 1'b1;
    else if (clr_ovr)                      ovr_q <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected frames, a
// line monitor decodes tx_out cycle by cycle against a frame model.
module tb_uart_tx_cfg;
  localparam int DW = 8, DEPTH = 4, CPB = 4, LW = $clog2(DEPTH) + 1;

  logic txclk = 1'b0, reset = 1'b1;
  logic tx_enable = 1'b0, stop2 = 1'b0, clr_ovr = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic parity_odd = 1'b0;
`endif
  logic          tx_out, tx_empty, tx_busy, tx_over_run;
  logic [LW-1:0] fifo_level;

  uart_tx_cfg_if #(.DATA_W(DW)) bus();

  uart_tx_cfg #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .txclk       (txclk),
    .reset       (reset),
    .bus         (bus.slave),
    .tx_enable   (tx_enable),
    .stop2       (stop2),
    .clr_ovr     (clr_ovr),
`ifdef UART_TX_PARITY_EN
    .parity_odd  (parity_odd),
`endif
    .tx_out      (tx_out),
    .tx_empty    (tx_empty),
    .tx_busy     (tx_busy),
    .tx_over_run (tx_over_run),
    .fifo_level  (fifo_level)
  );

  always #5 txclk = ~txclk;

  int cyc = 0;
  always @(posedge txclk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic          s2;
    logic          po;
  } frame_t;

  frame_t exp_q[$];
  int     gap_q[$];
  int     errors = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level picture of one frame: start, data LSB first, parity, stops.
  function automatic int build(input frame_t f, output logic [15:0] bits);
    int n = 0;
    bits = '1;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin bits[n] = f.d[i]; n++; end
`ifdef UART_TX_PARITY_EN
    bits[n] = ((($countones(f.d) % 2) == 1) ? 1'b1 : 1'b0) ^ f.po; n++;
`endif
    bits[n] = 1'b1; n++;
    if (f.s2) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  function automatic logic po_now();
`ifdef UART_TX_PARITY_EN
    return parity_odd;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every low on an idle line is a frame start; each bit must hold
  // its value for exactly CPB cycles.
  initial begin : monitor
    frame_t       f;
    logic [15:0]  bits;
    int           n, prev_end, nfr, nbad;
    bit           aborted;
    prev_end = -1000;
    nfr = 0;
    forever begin
      @(negedge txclk);
      if (reset !== 1'b0 || tx_out !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        chk("frame_expected", exp_q.size(), 1);
        while (tx_out === 1'b0 && reset === 1'b0) @(negedge txclk);
        continue;
      end
      f = exp_q.pop_front();
      gap_q.push_back(cyc - prev_end - 1);
      n = build(f, bits);
      aborted = 0;
      for (int b = 0; b < n && !aborted; b++) begin
        nbad = 0;
        for (int c = 0; c < CPB; c++) begin
          if (b != 0 || c != 0) @(negedge txclk);
          if (reset !== 1'b0) begin aborted = 1; break; end
          if (tx_out !== bits[b]) nbad++;
        end
        if (!aborted) chk($sformatf("frame%0d_bit%0d_bad_cycles", nfr, b), nbad, 0);
      end
      prev_end = cyc;
      nfr++;
    end
  end

  task automatic push(input logic [DW-1:0] d, output bit acc);
    frame_t f;
    @(negedge txclk);
    acc = bus.ld_ready;
    bus.ld_tx_data = 1'b1;
    bus.tx_data    = d;
    if (acc) begin
      f.d = d; f.s2 = stop2; f.po = po_now();
      exp_q.push_back(f);
    end
    @(negedge txclk);
    bus.ld_tx_data = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge txclk);
      if (tx_empty === 1'b1 && exp_q.size() == 0) break;
    end
    chk(nm, (i < lim), 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int mdl_lvl, i, nw;
    bus.ld_tx_data = 1'b0;
    bus.tx_data    = '0;
    repeat (3) @(negedge txclk);
    reset = 1'b0;
    chk("rst_tx_out", tx_out, 1);
    chk("rst_tx_empty", tx_empty, 1);
    chk("rst_tx_busy", tx_busy, 0);
    chk("rst_over_run", tx_over_run, 0);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_level", fifo_level, 0);

    // Single 0xA5 frame, one stop bit.
    tx_enable = 1'b1;
    push(8'hA5, acc);
    @(negedge txclk);
    chk("busy_during_frame", tx_busy, 1);
    chk("empty_during_frame", tx_empty, 0);
    wait_idle(100, "a5_idle_reached");
    chk("a5_level_after", fifo_level, 0);

    // Fill while disabled: overrun on the fifth push.
    tx_enable = 1'b0;
    mdl_lvl = 0;
    for (int k = 1; k <= 5; k++) begin
      push(DW'(k * 17), acc);
      chk($sformatf("fill%0d_ready_at_push", k), acc, (mdl_lvl < DEPTH));
      if (mdl_lvl < DEPTH) mdl_lvl++;
      chk($sformatf("fill%0d_level", k), fifo_level, mdl_lvl);
      chk($sformatf("fill%0d_ld_ready", k), bus.ld_ready, (mdl_lvl < DEPTH));
      chk($sformatf("fill%0d_over_run", k), tx_over_run, (k > DEPTH));
    end
    chk("disabled_no_start_busy", tx_busy, 0);
    chk("disabled_line_high", tx_out, 1);
    @(negedge txclk); bus.ld_tx_data = 1'b1; clr_ovr = 1'b1;
    @(negedge txclk); bus.ld_tx_data = 1'b0; clr_ovr = 1'b0;
    chk("ovr_set_wins_over_clear", tx_over_run, 1);
    @(negedge txclk); clr_ovr = 1'b1;
    @(negedge txclk); clr_ovr = 1'b0;
    chk("ovr_cleared", tx_over_run, 0);
    gap_q.delete();
    tx_enable = 1'b1;
    wait_idle(400, "drain4_idle_reached");
    chk("drain4_frames", gap_q.size(), 4);
    for (int k = 1; k < 4 && k < gap_q.size(); k++)
      chk($sformatf("drain4_gap%0d", k), gap_q[k], 0);

    // Two stop bits between back-to-back 0x00 and 0xFF.
    tx_enable = 1'b0;
    stop2 = 1'b1;
    push(8'h00, acc);
    push(8'hFF, acc);
    gap_q.delete();
    tx_enable = 1'b1;
    wait_idle(200, "stop2_idle_reached");
    chk("stop2_frames", gap_q.size(), 2);
    if (gap_q.size() > 1) chk("stop2_gap", gap_q[1], 0);
    stop2 = 1'b0;

    // Enable dropped mid-frame: current frame finishes, queued ones wait.
    push(8'h81, acc);
    push(8'h42, acc);
    push(8'h24, acc);
    @(negedge txclk);
    tx_enable = 1'b0;
    repeat (120) @(negedge txclk);
    chk("drop_en_busy", tx_busy, 0);
    chk("drop_en_level", fifo_level, 2);
    chk("drop_en_line", tx_out, 1);
    tx_enable = 1'b1;
    wait_idle(300, "drop_en_idle_reached");

`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b1;
    push(8'h03, acc);
    wait_idle(100, "par_odd_idle_reached");
    parity_odd = 1'b0;
    push(8'h03, acc);
    wait_idle(100, "par_even_idle_reached");
`endif

    // Randomized batches; stop2/parity only change while idle.
    for (int it = 0; it < 25; it++) begin
      stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
      parity_odd = 1'($urandom_range(0, 1));
`endif
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) begin
        tx_enable = ($urandom_range(0, 3) != 0);
        push(DW'($urandom_range(0, 255)), acc);
        repeat ($urandom_range(0, 20)) @(negedge txclk);
      end
      tx_enable = 1'b1;
      wait_idle(600, $sformatf("rand%0d_idle_reached", it));
    end
    stop2 = 1'b0;

    // Reset during data bit 3 of a frame with words still queued.
    tx_enable = 1'b0;
    push(8'h5A, acc);
    push(8'h11, acc);
    push(8'h22, acc);
    tx_enable = 1'b1;
    for (i = 0; i < 100; i++) begin
      @(negedge txclk);
      if (tx_out === 1'b0) break;
    end
    chk("rst_mid_start_seen", (i < 100), 1);
    repeat ((1 + 3) * CPB + 1) @(negedge txclk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx_out", tx_out, 1);
    chk("rst_mid_level", fifo_level, 0);
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_empty", tx_empty, 1);
    exp_q.delete();
    repeat (2) @(negedge txclk);
    reset = 1'b0;
    push(8'h3C, acc);
    wait_idle(100, "post_rst_idle_reached");

    repeat (5) @(negedge txclk);
    chk("leftover_frames", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
